bist_scheduler: RTL

- Top-level sequencer for the 256x4b SRAM BIST engine.
- On a single `go`, it runs every algorithm selected in `algo_mask` back-to-back, in ascending index order. It drives the engine's start/test_sel and waits for each run's done.
- It keeps a per-algorithm failure log: saturating fail count and first failing address.
- It reports one overall pass/fail verdict. It sits between the system/JTAG control register block and the BIST engine.

---
 rtl/bist_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bist_scheduler.sv
// Sequences the SRAM BIST engine over every algorithm in algo_mask and keeps a per-algorithm fail log.
// Optional run watchdog: define BIST_SCHED_TIMEOUT_EN.
module bist_scheduler #(
  parameter int NUM_ALGOS      = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int ADDR_WIDTH     = 8,
  parameter int CNT_WIDTH      = 10,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [NUM_ALGOS-1:0]  algo_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [SEL_WIDTH-1:0]  cur_algo,
  output logic                  bist_start,
  output logic [SEL_WIDTH-1:0]  bist_test_sel,
  input  logic                  bist_done,
  input  logic                  bist_fail,
  input  logic [ADDR_WIDTH-1:0] bist_fail_addr,
  input  logic [SEL_WIDTH-1:0]  log_sel,
  output logic [CNT_WIDTH-1:0]  log_fail_cnt,
  output logic [ADDR_WIDTH-1:0] log_first_addr,
  output logic                  log_valid,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {IDLE, SCAN, RUN, GAP, DONE} state_t;

  state_t                state_q, state_d;
  logic [NUM_ALGOS-1:0]  pending_q, pending_d;
  logic [NUM_ALGOS-1:0]  valid_q, valid_d;
  logic [SEL_WIDTH-1:0]  cur_algo_q, cur_algo_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_ALGOS];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_ALGOS];
  logic [ADDR_WIDTH-1:0] addr_q [NUM_ALGOS];
  logic [ADDR_WIDTH-1:0] addr_d [NUM_ALGOS];

  logic                  found;
  logic [SEL_WIDTH-1:0]  low_idx;
  logic                  no_fails;

`ifdef BIST_SCHED_TIMEOUT_EN
  logic [14:0] wd_q, wd_d;
  logic        timeout_err_q, timeout_err_d;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Lowest pending index wins, giving ascending run order.
  always_comb begin
    found   = 1'b0;
    low_idx = '0;
    for (int i = 0; i < NUM_ALGOS; i++) begin
      if (pending_q[i] && !found) begin
        found   = 1'b1;
        low_idx = SEL_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    valid_d    = valid_q;
    cur_algo_d = cur_algo_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
`ifdef BIST_SCHED_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          pending_d = algo_mask;
          valid_d   = '0;
          cnt_d     = '{default: '0};
          addr_d    = '{default: '0};
`ifdef BIST_SCHED_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (found) begin
          cur_algo_d         = low_idx;
          pending_d[low_idx] = 1'b0;
          valid_d[low_idx]   = 1'b1;
`ifdef BIST_SCHED_TIMEOUT_EN
          wd_d = '0;
`endif
          state_d = RUN;
        end else begin
          state_d = DONE;
        end
      end
      RUN: begin
        // A fail coinciding with bist_done still belongs to this run.
        if (bist_fail) begin
          if (cnt_q[cur_algo_q] == '0) addr_d[cur_algo_q] = bist_fail_addr;
          if (cnt_q[cur_algo_q] != '1) cnt_d[cur_algo_q] = cnt_q[cur_algo_q] + 1'b1;
        end
`ifdef BIST_SCHED_TIMEOUT_EN
        wd_d = wd_q + 15'd1;
        if (bist_done) begin
          state_d = GAP;
        end else if (wd_q == 15'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = GAP;
        end
`else
        if (bist_done) state_d = GAP;
`endif
      end
      GAP:     state_d = SCAN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      valid_q    <= '0;
      cur_algo_q <= '0;
      cnt_q      <= '{default: '0};
      addr_q     <= '{default: '0};
`ifdef BIST_SCHED_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      valid_q    <= valid_d;
      cur_algo_q <= cur_algo_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
`ifdef BIST_SCHED_TIMEOUT_EN
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  always_comb begin
    no_fails = 1'b1;
    for (int i = 0; i < NUM_ALGOS; i++) begin
      if (cnt_q[i] != '0) no_fails = 1'b0;
    end
  end

  assign busy          = (state_q == SCAN) || (state_q == RUN) || (state_q == GAP);
  assign done          = (state_q == DONE);
  assign pass          = done && no_fails && !timeout_err;
  assign cur_algo      = cur_algo_q;
  assign bist_start    = (state_q == RUN);
  assign bist_test_sel = cur_algo_q;

  always_comb begin
    log_fail_cnt   = '0;
    log_first_addr = '0;
    log_valid      = 1'b0;
    if (int'(log_sel) < NUM_ALGOS) begin
      log_fail_cnt   = cnt_q[log_sel];
      log_first_addr = addr_q[log_sel];
      log_valid      = valid_q[log_sel];
    end
  end

endmodule
